// File: rtl/vga_sync_vertical.sv
// Vertical half of the VGA timing generator: counts lines from the horizontal counter's
// advance pulse, decodes registered sync/blanking outputs and watches the line cadence.
module vga_sync_vertical #(
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33,
  parameter int unsigned LINE_TIMEOUT = 3300
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] cntHorizontal,
  input  logic       vflag,
  output logic [9:0] cntVertical,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic       line_err
);

  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned TmoW   = $clog2(LINE_TIMEOUT + 1);

  localparam logic [9:0]      HVisEnd   = 10'(H_VISIBLE);
  localparam logic [9:0]      HSyncBeg  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]      HSyncEnd  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]      VLast     = 10'(VTotal - 1);
  localparam logic [9:0]      VFrontBeg = 10'(V_VISIBLE);
  localparam logic [9:0]      VSyncBeg  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]      VBackBeg  = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [TmoW-1:0] TmoMax    = TmoW'(LINE_TIMEOUT);

  typedef enum logic [1:0] {StActive, StFront, StSync, StBack} state_e;

  state_e          state_q, state_d;
  logic [9:0]      cnt_v_q, cnt_v_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            vflag_q;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            video_on_q, video_on_d;
  logic            frame_start_q, frame_start_d;
  logic            line_err_q, line_err_d;
  logic            line_acc;

  assign line_acc = vflag & ~vflag_q;

  always_comb begin
    cnt_v_d       = cnt_v_q;
    state_d       = state_q;
    frame_start_d = 1'b0;
    if (line_acc) begin
      if (cnt_v_q == VLast) begin
        cnt_v_d       = '0;
        frame_start_d = 1'b1;
      end else begin
        cnt_v_d = cnt_v_q + 10'd1;
      end
      // State follows the new count so vsync lines up with cntVertical.
      if (cnt_v_d == 10'd0) begin
        state_d = StActive;
      end else if (cnt_v_d == VFrontBeg) begin
        state_d = StFront;
      end else if (cnt_v_d == VSyncBeg) begin
        state_d = StSync;
      end else if (cnt_v_d == VBackBeg) begin
        state_d = StBack;
      end
    end
    vsync_d = (state_d != StSync);
  end

  always_comb begin
    hsync_d    = ~((cntHorizontal >= HSyncBeg) && (cntHorizontal <= HSyncEnd));
    video_on_d = (cntHorizontal < HVisEnd) && (state_q == StActive);
  end

  // An accepted line clears the watchdog, so it beats a coincident timeout.
  always_comb begin
    if (line_acc) begin
      tmo_d = '0;
    end else if (tmo_q < TmoMax) begin
      tmo_d = tmo_q + TmoW'(1);
    end else begin
      tmo_d = tmo_q;
    end
    line_err_d = line_err_q | (tmo_d == TmoMax);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= StActive;
      cnt_v_q       <= '0;
      tmo_q         <= '0;
      vflag_q       <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_v_q       <= cnt_v_d;
      tmo_q         <= tmo_d;
      vflag_q       <= vflag;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      line_err_q    <= line_err_d;
    end
  end

  assign cntVertical = cnt_v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;
  assign line_err    = line_err_q;

endmodule

// File: tb/tb_vga_sync_vertical.sv
// Directed bench for vga_sync_vertical: reset, full frame walk, horizontal decode,
// held vflag, line watchdog and mid-frame reset.
module tb_vga_sync_vertical;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       vflag;
  logic [9:0] cntHorizontal;
  logic [9:0] cntVertical;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;
  logic       line_err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [9:0]  exp_cnt  = 10'd0;
  int          vcnt;
  int          hcnt;

  always #5 Clk = ~Clk;

  vga_sync_vertical dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .cntHorizontal(cntHorizontal),
    .vflag        (vflag),
    .cntVertical  (cntVertical),
    .hsync        (hsync),
    .vsync        (vsync),
    .video_on     (video_on),
    .frame_start  (frame_start),
    .line_err     (line_err)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk_c(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic pulse();
    vflag = 1'b1;
    tick();
    exp_cnt = (exp_cnt == 10'd524) ? 10'd0 : exp_cnt + 10'd1;
    chk_c("pulse_cnt", cntVertical, exp_cnt);
    vflag = 1'b0;
    tick();
  endtask

  task automatic advance_to(input logic [9:0] target);
    while (exp_cnt != target) pulse();
  endtask

  task automatic sweep(input logic vis_allowed, input string tag);
    vcnt = 0;
    hcnt = 0;
    for (int h = 0; h < 800; h++) begin
      cntHorizontal = 10'(h);
      tick();
      chk_b({tag, "_video"}, video_on, vis_allowed && (h < 640));
      chk_b({tag, "_hsync"}, hsync, !((h >= 656) && (h <= 751)));
      if (video_on) vcnt++;
      if (!hsync) hcnt++;
    end
    chk_c({tag, "_video_cycles"}, 10'(vcnt), vis_allowed ? 10'd640 : 10'd0);
    chk_c({tag, "_hsync_cycles"}, 10'(hcnt), 10'd96);
  endtask

  initial begin
    Reset         = 1'b1;
    vflag         = 1'b0;
    cntHorizontal = 10'd0;

    // Reset held while inputs move.
    for (int i = 0; i < 10; i++) begin
      vflag         = i[0];
      cntHorizontal = 10'(i * 80);
      tick();
      chk_c("rst_cnt", cntVertical, 10'd0);
      chk_b("rst_hsync", hsync, 1'b1);
      chk_b("rst_vsync", vsync, 1'b1);
      chk_b("rst_video", video_on, 1'b0);
      chk_b("rst_fs", frame_start, 1'b0);
      chk_b("rst_err", line_err, 1'b0);
    end

    Reset         = 1'b0;
    vflag         = 1'b0;
    cntHorizontal = 10'd0;
    tick();
    chk_c("rel_cnt", cntVertical, 10'd0);

    // Full frame: 525 single-cycle pulses.
    for (int ln = 1; ln <= 525; ln++) begin
      vflag = 1'b1;
      tick();
      exp_cnt = (exp_cnt == 10'd524) ? 10'd0 : exp_cnt + 10'd1;
      chk_c("frame_cnt", cntVertical, exp_cnt);
      chk_b("frame_fs", frame_start, ln == 525);
      chk_b("frame_vsync", vsync, !((exp_cnt == 10'd490) || (exp_cnt == 10'd491)));
      vflag = 1'b0;
      tick();
      chk_b("frame_fs_off", frame_start, 1'b0);
      chk_c("frame_cnt_hold", cntVertical, exp_cnt);
      tick();
      tick();
    end
    chk_b("frame_err", line_err, 1'b0);

    // Horizontal decode in the visible band and in the front porch.
    advance_to(10'd10);
    sweep(1'b1, "sweep10");
    advance_to(10'd480);
    sweep(1'b0, "sweep480");

    // vflag held high counts as a single line.
    advance_to(10'd7);
    vflag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_c("held_cnt", cntVertical, 10'd8);
    end
    vflag = 1'b0;
    exp_cnt = 10'd8;
    tick();
    chk_c("held_cnt_after", cntVertical, 10'd8);
    cntHorizontal = 10'd100;
    tick();
    chk_b("h100_video", video_on, 1'b1);
    chk_b("h100_hsync", hsync, 1'b1);
    cntHorizontal = 10'd700;
    tick();
    chk_b("h700_hsync", hsync, 1'b0);
    cntHorizontal = 10'd900;
    tick();
    chk_b("h900_hsync", hsync, 1'b1);
    chk_b("h900_video", video_on, 1'b0);
    chk_c("h900_cnt", cntVertical, 10'd8);
    cntHorizontal = 10'd0;

    // Watchdog: 3300 edges without an accepted line sets line_err.
    pulse();
    repeat (3298) tick();
    chk_b("tmo_before", line_err, 1'b0);
    tick();
    chk_b("tmo_at", line_err, 1'b1);
    pulse();
    pulse();
    chk_b("tmo_sticky", line_err, 1'b1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_cnt = 10'd0;
    chk_b("tmo_rst", line_err, 1'b0);
    chk_c("tmo_rst_cnt", cntVertical, 10'd0);

    // Accepted line coinciding with the threshold edge wins.
    pulse();
    repeat (3298) tick();
    chk_b("tie_before", line_err, 1'b0);
    pulse();
    chk_b("tie_err", line_err, 1'b0);
    repeat (10) tick();
    chk_b("tie_err_later", line_err, 1'b0);

    // Mid-frame resets.
    advance_to(10'd300);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_cnt = 10'd0;
    chk_c("rst300_cnt", cntVertical, 10'd0);
    chk_b("rst300_vsync", vsync, 1'b1);
    chk_b("rst300_fs", frame_start, 1'b0);
    advance_to(10'd491);
    chk_b("at491_vsync", vsync, 1'b0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_cnt = 10'd0;
    chk_c("rst491_cnt", cntVertical, 10'd0);
    chk_b("rst491_vsync", vsync, 1'b1);
    chk_b("rst491_fs", frame_start, 1'b0);
    cntHorizontal = 10'd5;
    tick();
    chk_b("rst491_fs_next", frame_start, 1'b0);
    tick();
    chk_b("rst491_active", video_on, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
